// File: rtl/alu_pkg.sv
// Shared op encodings and control states for the serial ALU.
// Flag outputs are enabled by SERIAL_ALU_FLAGS_EN.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_is_sub(
    input logic [2:0] op
  );
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic op_is_arith(
    input logic [2:0] op
  );
    return (op == OP_ADD) || op_is_sub(op);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// One SLICE-wide combinational op/adder slice.
// Exposes the carry into the MSB so the caller can form signed overflow.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic [SLICE-1:0] y,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] bx;
  logic [SLICE:0]   sum;

  assign bx  = op_is_sub(op) ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx}
             + {{SLICE{1'b0}}, cin};

  // sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of it
  assign c_msb = sum[SLICE-1] ^ a[SLICE-1] ^ bx[SLICE-1];

  always_comb begin
    y    = sum[SLICE-1:0];
    cout = 1'b0;
    unique case (1'b1)
      op_is_arith(op): begin
        y    = sum[SLICE-1:0];
        cout = sum[SLICE];
      end
      (op == OP_XOR):  y = a ^ b;
      (op == OP_AND):  y = a & b;
      (op == OP_NAND): y = ~(a & b);
      (op == OP_NOR):  y = ~(a | b);
      (op == OP_OR):   y = a | b;
      default:         y = sum[SLICE-1:0];
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Slice-serial ALU: WIDTH/SLICE cycles per op, valid/ready on both sides.
// Define SERIAL_ALU_FLAGS_EN to add carryout/overflow/zero outputs.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("serial_alu: WIDTH must be a multiple of SLICE");
  end

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res_nx;
  logic [2:0]       op_r;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             last;

  logic [SLICE-1:0] s_a;
  logic [SLICE-1:0] s_b;
  logic [SLICE-1:0] s_y;
  logic             s_cout;
  logic             s_cmsb;

  assign s_a  = a_r[int'(cnt)*SLICE +: SLICE];
  assign s_b  = b_r[int'(cnt)*SLICE +: SLICE];
  assign last = (cnt == CW'(N-1));

  alu_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a     (s_a),
    .b     (s_b),
    .op    (op_r),
    .cin   (carry),
    .y     (s_y),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = RUN;
      RUN:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // SLT keeps only the signed-less-than bit: sign ^ overflow
  always_comb begin
    res_nx = acc;
    res_nx[int'(cnt)*SLICE +: SLICE] = s_y;
    if (op_r == OP_SLT) begin
      res_nx = {{(WIDTH-1){1'b0}},
                s_y[SLICE-1] ^ s_cmsb ^ s_cout};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= OP_ADD;
      acc    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= op;
            acc   <= '0;
            cnt   <= '0;
            carry <= op_is_sub(op);
          end
        end
        RUN: begin
          acc[int'(cnt)*SLICE +: SLICE] <= s_y;
          carry <= s_cout;
          cnt   <= cnt + 1'b1;
          if (last) result <= res_nx;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  logic add_sub;

  assign add_sub = (op_r == OP_ADD) || (op_r == OP_SUB);

  always_ff @(posedge clk) begin
    if (reset) begin
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (state == RUN && last) begin
      carryout <= s_cout;
      overflow <= add_sub & (s_cmsb ^ s_cout);
      zero     <= (res_nx == '0);
    end
  end
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu with a transaction-level reference model.
module tb_serial_alu;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
`ifdef SERIAL_ALU_FLAGS_EN
  logic         carryout;
  logic         overflow;
  logic         zero;
`endif

  always #5 clk = ~clk;

  serial_alu #(
    .WIDTH (W),
    .SLICE (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    .carryout  (carryout),
    .overflow  (overflow),
    .zero      (zero)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  function automatic void model(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [2:0]  o,
    output logic [31:0] r,
    output logic        c,
    output logic        v,
    output logic        z);
    logic [32:0] s;
    c = 1'b0;
    v = 1'b0;
    s = {1'b0, x} + {1'b0, ~y} + 33'd1;
    case (o)
      OP_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0];
        c = s[32];
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      OP_SUB: begin
        r = x - y;
        c = s[32];
        v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      OP_SLT: begin
        r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        c = s[32];
      end
      OP_XOR:  r = x ^ y;
      OP_AND:  r = x & y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      default: r = x | y;
    endcase
    z = (r == 32'd0);
  endfunction

  // reference: 0 idle, 1 busy for N edges, 2 holding result
  int          m_st = 0;
  int          m_cnt = 0;
  bit          live = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] p_res;
  logic        m_c = 0, m_v = 0, m_z = 0;
  logic        p_c, p_v, p_z;

  always @(posedge clk) begin
    if (reset) begin
      m_st  = 0;
      m_res = '0;
      m_c   = 0;
      m_v   = 0;
      m_z   = 0;
      live  = 1'b1;
    end else if (m_st == 0) begin
      if (in_valid) begin
        model(a, b, op, p_res, p_c, p_v, p_z);
        m_cnt = N;
        m_st  = 1;
      end
    end else if (m_st == 1) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_st  = 2;
        m_res = p_res;
        m_c   = p_c;
        m_v   = p_v;
        m_z   = p_z;
      end
    end else if (out_ready) begin
      m_st = 0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(m_st == 0));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_st == 2));
      chk("cyc_result", result, m_res);
`ifdef SERIAL_ALU_FLAGS_EN
      chk("cyc_carryout", 32'(carryout), 32'(m_c));
      chk("cyc_overflow", 32'(overflow), 32'(m_v));
      chk("cyc_zero", 32'(zero), 32'(m_z));
`endif
    end
  end

  task automatic issue(input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [2:0]  o);
    a        = x;
    b        = y;
    op       = o;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // called right after the accept edge; junk inputs while busy
  task automatic wait_done(input string nm,
                           input logic [31:0] er,
                           input logic ec,
                           input logic ev,
                           input logic ez);
    int lat;
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin
        in_valid = 1'b1;
        a        = $urandom;
        b        = $urandom;
        op       = 3'($urandom);
      end
      if (k == 5) in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_latency"}, lat, N);
    chk(nm, result, er);
`ifdef SERIAL_ALU_FLAGS_EN
    chk({nm, "_c"}, 32'(carryout), 32'(ec));
    chk({nm, "_v"}, 32'(overflow), 32'(ev));
    chk({nm, "_z"}, 32'(zero), 32'(ez));
`else
    if (ec & ev & ez & 1'b0) $display("unused");
`endif
  endtask

  task automatic release_out(input int hold);
    repeat (hold) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("back_to_idle", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  o;
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"add_ovf",  32'h7FFFFFFF, 32'h00000001, OP_ADD,
                 32'h80000000, 0, 1, 0};
    vecs[1]  = '{"sub_eq",   32'd5, 32'd5, OP_SUB,
                 32'h0, 1, 0, 1};
    vecs[2]  = '{"slt_neg",  32'hFFFFFFFF, 32'h1, OP_SLT,
                 32'h1, 1, 0, 0};
    vecs[3]  = '{"slt_pos",  32'h1, 32'hFFFFFFFF, OP_SLT,
                 32'h0, 0, 0, 1};
    vecs[4]  = '{"nand_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, OP_NAND,
                 32'h0, 0, 0, 1};
    vecs[5]  = '{"or_mix",   32'hF0F00000, 32'h0000F0F0, OP_OR,
                 32'hF0F0F0F0, 0, 0, 0};
    vecs[6]  = '{"xor",      32'h12345678, 32'hFFFF0000, OP_XOR,
                 32'hEDCB5678, 0, 0, 0};
    vecs[7]  = '{"and",      32'hA5A5A5A5, 32'h0F0F0F0F, OP_AND,
                 32'h05050505, 0, 0, 0};
    vecs[8]  = '{"nor_zero", 32'h0, 32'h0, OP_NOR,
                 32'hFFFFFFFF, 0, 0, 0};
    vecs[9]  = '{"add_wrap", 32'hFFFFFFFF, 32'h1, OP_ADD,
                 32'h0, 1, 0, 1};
    vecs[10] = '{"sub_neg",  32'd3, 32'd5, OP_SUB,
                 32'hFFFFFFFE, 0, 0, 0};
    vecs[11] = '{"sub_ovf",  32'h80000000, 32'h1, OP_SUB,
                 32'h7FFFFFFF, 1, 1, 0};
    vecs[12] = '{"slt_ovf",  32'h80000000, 32'h7FFFFFFF, OP_SLT,
                 32'h1, 1, 0, 0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
`ifdef SERIAL_ALU_FLAGS_EN
    chk("rst_flags", {29'd0, carryout, overflow, zero}, 32'd0);
`endif

    foreach (vecs[i]) begin
      issue(vecs[i].x, vecs[i].y, vecs[i].o);
      wait_done(vecs[i].nm, vecs[i].r,
                vecs[i].c, vecs[i].v, vecs[i].z);
      release_out((i == 5) ? 5 : 0);
    end

    // release and new request in the same cycle: no re-accept
    issue(32'd10, 32'd20, OP_ADD);
    wait_done("add_hold", 32'd30, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_result", result, 32'd30);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 32'd100;
    b         = 32'd1;
    op        = OP_SUB;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("no_same_cycle_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("reaccept", 32'(in_ready), 32'd0);
    wait_done("sub_after", 32'd99, 1, 0, 0);
    release_out(0);

    // reset mid-run at count 3
    issue(32'h11111111, 32'h22222222, OP_ADD);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_stale", 32'(out_valid), 32'd0);
    chk("midrst_result_late", result, 32'd0);

    issue(32'h11111111, 32'h22222222, OP_ADD);
    wait_done("add_post_rst", 32'h33333333, 0, 0, 0);
    release_out(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
